// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the OCI trace FIFO: overflow policy codes and the
// per-cycle accept rule.
package nios2_oci_trace_pkg;

  localparam int unsigned TRC_OVF_TRUNCATE = 0;
  localparam int unsigned TRC_OVF_ATOMIC   = 1;

  // Words taken from a group of in_cnt given free slots at cycle start.
  function automatic int unsigned trc_accept(input int unsigned in_cnt,
                                             input int unsigned free,
                                             input bit          atomic);
    if (in_cnt <= free) return in_cnt;
    return atomic ? 32'd0 : free;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo_ram.sv
// DEPTH x WIDTH trace storage: MAX_IN write ports, one registered read port.
// The array itself is never reset; only the read register is.
module nios2_oci_trace_fifo_ram
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned MAX_IN = 3,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rd_rst,
  input  logic [MAX_IN-1:0]       we,
  input  logic [MAX_IN*AW-1:0]    waddr,
  input  logic [MAX_IN*WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Ports in one group always target distinct entries, so no write ordering matters.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < MAX_IN; k++) begin
      if (we[k]) mem[waddr[k*AW +: AW]] <= wdata[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_rst)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nios2_oci_trace_fifo_mw.sv
// Multi-word Nios II OCI trace FIFO: up to MAX_IN words in per cycle, one out,
// with truncate/atomic overflow policy and saturating drop statistics.
module nios2_oci_trace_fifo_mw
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned MAX_IN = 3,
  parameter int unsigned ATOMIC = TRC_OVF_TRUNCATE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [$clog2(MAX_IN+1)-1:0]  in_cnt,
  input  logic [MAX_IN*WIDTH-1:0]      in_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH+1);

  logic [AW-1:0]        wrptr, rdptr;
  int unsigned          in_eff, acc, drop;
  logic                 live, pop;
  logic [MAX_IN-1:0]    we;
  logic [MAX_IN*AW-1:0] waddr;
  logic [16:0]          drop_sum;

  // Free space is taken from the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    live   = !reset && !clear;
    in_eff = 32'(in_cnt);
    if (in_eff > MAX_IN) in_eff = MAX_IN;
    acc      = trc_accept(in_eff, DEPTH - 32'(count), ATOMIC == TRC_OVF_ATOMIC);
    drop     = in_eff - acc;
    pop      = live && rd_en && (count != '0);
    drop_sum = {1'b0, drop_cnt} + 17'(drop);
    we       = '0;
    waddr    = '0;
    for (int unsigned k = 0; k < MAX_IN; k++) begin
      we[k]               = live && (k < acc);
      waddr[k*AW +: AW]   = wrptr + AW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr    <= '0;
      rdptr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wrptr    <= '0;
      rdptr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wrptr    <= wrptr + AW'(acc);
      rdptr    <= rdptr + AW'(pop);
      count    <= count + NW'(acc) - NW'(pop);
      rd_valid <= pop;
      if (drop != 0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == NW'(DEPTH));

  nios2_oci_trace_fifo_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .MAX_IN (MAX_IN),
    .AW     (AW)
  ) u_ram (
    .clk    (clk),
    .rd_rst (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (in_data),
    .re     (pop),
    .raddr  (rdptr),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_nios2_oci_trace_fifo_mw.sv
// Scoreboard bench for nios2_oci_trace_fifo_mw: truncate-mode instance is
// modelled word by word, an atomic-mode instance shares the stimulus.
module tb_nios2_oci_trace_fifo_mw;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic [1:0]   in_cnt = '0;
  logic [107:0] in_data = '0;
  logic         rd_en = 1'b0;

  logic [35:0]  rd_data,  a_rd_data;
  logic         rd_valid, a_rd_valid;
  logic [4:0]   count,    a_count;
  logic         empty, full, overflow, a_empty, a_full, a_overflow;
  logic [15:0]  drop_cnt, a_drop_cnt;

  int unsigned  pass_cnt = 0;
  int unsigned  total_cnt = 0;

  logic [35:0]  m_q[$];
  logic [35:0]  exp_q[$];
  logic [35:0]  last_words [3];
  logic [35:0]  last_rd = '0;
  int unsigned  m_drop = 0;
  bit           m_ovf = 1'b0;

  always #5 clk = ~clk;

  nios2_oci_trace_fifo_mw #(
    .DEPTH(16), .WIDTH(36), .MAX_IN(3),
    .ATOMIC(nios2_oci_trace_pkg::TRC_OVF_TRUNCATE)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_cnt(in_cnt), .in_data(in_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  nios2_oci_trace_fifo_mw #(
    .DEPTH(16), .WIDTH(36), .MAX_IN(3),
    .ATOMIC(nios2_oci_trace_pkg::TRC_OVF_ATOMIC)
  ) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_cnt(in_cnt), .in_data(in_data),
    .rd_en(rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count),
    .empty(a_empty), .full(a_full), .overflow(a_overflow), .drop_cnt(a_drop_cnt)
  );

  // Output side of the scoreboard: each accepted pop must surface one cycle later.
  always @(negedge clk) begin
    logic [35:0] e;
    bit          ev;
    if (!reset) begin
      ev = (exp_q.size() > 0);
      total_cnt++;
      if (rd_valid !== ev) $display("FAIL rd_valid: got %b expected %b", rd_valid, ev);
      else pass_cnt++;
      if (ev) begin
        e = exp_q.pop_front();
        last_rd = e;
        total_cnt++;
        if (rd_data !== e) $display("FAIL rd_data: got %h expected %h", rd_data, e);
        else pass_cnt++;
      end
    end
  end

  // One clock of stimulus; the truncate-mode model is advanced with the same inputs.
  task automatic cycle(input int unsigned cnt, input bit rd, input bit clr);
    int unsigned start, eff, acc;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      last_words[k] = {4'($urandom), $urandom};
      in_data[k*36 +: 36] = last_words[k];
    end
    in_cnt = 2'(cnt);
    rd_en  = rd;
    clear  = clr;
    if (clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      start = m_q.size();
      eff   = (cnt > 3) ? 3 : cnt;
      acc   = (eff <= 16 - start) ? eff : 16 - start;
      if (rd && start > 0) exp_q.push_back(m_q.pop_front());
      for (int unsigned k = 0; k < acc; k++) m_q.push_back(last_words[k]);
      if (eff > acc) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + eff - acc > 65535) ? 65535 : m_drop + eff - acc;
      end
    end
    @(posedge clk); #1;
    in_cnt = '0;
    rd_en  = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; in_cnt = '0; rd_en = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete(); exp_q.delete();
    m_drop = 0; m_ovf = 1'b0; last_rd = '0;
  endtask

  task automatic drain(input int unsigned n);
    repeat (n) cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt += 8;
    if (rd_data !== 36'd0)   $display("FAIL reset_rd_data: got %h expected 0", rd_data);   else pass_cnt++;
    if (rd_valid !== 1'b0)   $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else pass_cnt++;
    if (count !== 5'd0)      $display("FAIL reset_count: got %0d expected 0", count);      else pass_cnt++;
    if (empty !== 1'b1)      $display("FAIL reset_empty: got %b expected 1", empty);       else pass_cnt++;
    if (full !== 1'b0)       $display("FAIL reset_full: got %b expected 0", full);         else pass_cnt++;
    if (overflow !== 1'b0)   $display("FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
    if (drop_cnt !== 16'd0)  $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else pass_cnt++;
    if (a_count !== 5'd0)    $display("FAIL reset_a_count: got %0d expected 0", a_count);  else pass_cnt++;
  endtask

  task automatic test_truncate();
    int exp_tab [6] = '{3, 6, 9, 12, 15, 16};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(3, 1'b0, 1'b0);
      total_cnt++;
      if (count !== 5'(exp_tab[i])) $display("FAIL trunc_count[%0d]: got %0d expected %0d", i, count, exp_tab[i]);
      else pass_cnt++;
    end
    total_cnt += 3;
    if (overflow !== 1'b1)  $display("FAIL trunc_overflow: got %b expected 1", overflow);   else pass_cnt++;
    if (drop_cnt !== 16'd2) $display("FAIL trunc_drop_cnt: got %0d expected 2", drop_cnt);  else pass_cnt++;
    if (full !== 1'b1)      $display("FAIL trunc_full: got %b expected 1", full);           else pass_cnt++;
    drain(16);
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL trunc_drained_empty: got %b expected 1", empty); else pass_cnt++;
  endtask

  task automatic test_atomic();
    int exp_tab [6] = '{3, 6, 9, 12, 15, 15};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(3, 1'b0, 1'b0);
      total_cnt++;
      if (a_count !== 5'(exp_tab[i])) $display("FAIL atomic_count[%0d]: got %0d expected %0d", i, a_count, exp_tab[i]);
      else pass_cnt++;
    end
    total_cnt += 3;
    if (a_drop_cnt !== 16'd3) $display("FAIL atomic_drop_cnt: got %0d expected 3", a_drop_cnt); else pass_cnt++;
    if (a_full !== 1'b0)      $display("FAIL atomic_full: got %b expected 0", a_full);         else pass_cnt++;
    if (a_overflow !== 1'b1)  $display("FAIL atomic_overflow: got %b expected 1", a_overflow); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [35:0] abc [3];
    do_reset();
    repeat (4) cycle(3, 1'b0, 1'b0);
    cycle(2, 1'b0, 1'b0);
    drain(14);
    cycle(3, 1'b0, 1'b0);
    abc = last_words;
    total_cnt++;
    if (count !== 5'd3) $display("FAIL wrap_count: got %0d expected 3", count); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, 1'b0);
      total_cnt += 2;
      if (rd_valid !== 1'b1) $display("FAIL wrap_rd_valid[%0d]: got %b expected 1", i, rd_valid); else pass_cnt++;
      if (rd_data !== abc[i]) $display("FAIL wrap_rd_data[%0d]: got %h expected %h", i, rd_data, abc[i]); else pass_cnt++;
    end
    cycle(0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (6) cycle(3, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b0);
    total_cnt += 2;
    if (count !== 5'd15) $display("FAIL b2b_count_pop: got %0d expected 15", count); else pass_cnt++;
    if (drop_cnt !== 16'(m_drop)) $display("FAIL b2b_drop_cnt: got %0d expected %0d", drop_cnt, m_drop); else pass_cnt++;
    cycle(1, 1'b0, 1'b0);
    total_cnt += 2;
    if (count !== 5'd16) $display("FAIL b2b_count_refill: got %0d expected 16", count); else pass_cnt++;
    if (full !== 1'b1)   $display("FAIL b2b_full: got %b expected 1", full); else pass_cnt++;
    drain(16);
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, 1'b0);
      total_cnt += 3;
      if (rd_valid !== 1'b0) $display("FAIL empty_rd_valid[%0d]: got %b expected 0", i, rd_valid); else pass_cnt++;
      if (count !== 5'd0)    $display("FAIL empty_count[%0d]: got %0d expected 0", i, count); else pass_cnt++;
      if (rd_data !== last_rd) $display("FAIL empty_rd_data[%0d]: got %h expected %h", i, rd_data, last_rd); else pass_cnt++;
    end
  endtask

  task automatic test_clear();
    do_reset();
    repeat (7) cycle(3, 1'b0, 1'b0);
    drain(9);
    total_cnt += 2;
    if (count !== 5'd7)     $display("FAIL clr_pre_count: got %0d expected 7", count); else pass_cnt++;
    if (drop_cnt !== 16'd5) $display("FAIL clr_pre_drop_cnt: got %0d expected 5", drop_cnt); else pass_cnt++;
    cycle(2, 1'b1, 1'b1);
    total_cnt += 4;
    if (count !== 5'd0)     $display("FAIL clr_count: got %0d expected 0", count); else pass_cnt++;
    if (overflow !== 1'b0)  $display("FAIL clr_overflow: got %b expected 0", overflow); else pass_cnt++;
    if (drop_cnt !== 16'd5) $display("FAIL clr_drop_cnt: got %0d expected 5", drop_cnt); else pass_cnt++;
    if (empty !== 1'b1)     $display("FAIL clr_empty: got %b expected 1", empty); else pass_cnt++;
  endtask

  task automatic test_saturation();
    repeat (6) cycle(3, 1'b0, 1'b0);
    repeat (23334) cycle(3, 1'b0, 1'b0);
    total_cnt += 3;
    if (drop_cnt !== 16'hFFFF) $display("FAIL sat_drop_cnt: got %h expected ffff", drop_cnt); else pass_cnt++;
    if (overflow !== m_ovf)    $display("FAIL sat_overflow: got %b expected %b", overflow, m_ovf); else pass_cnt++;
    if (count !== 5'd16)       $display("FAIL sat_count: got %0d expected 16", count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_truncate();
    test_atomic();
    test_wrap();
    test_back_to_back();
    test_empty_read();
    test_clear();
    test_saturation();
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
